// File: rtl/acss2_clk_pkg.sv
// Shared constants and types for the ACSS2 unbuffered clock generator.
package acss2_clk_pkg;

  localparam int DIV_W_DEF       = 8;
  localparam int SS_DIV_RST_DEF  = 4;
  localparam int RCC_DIV_RST_DEF = 2;

  // Half-period field at the default width.
  typedef logic [DIV_W_DEF-1:0] div_t;

endpackage

// File: rtl/acss2_clkdiv_ch.sv
// One divided-clock channel: half-period counter, output flop, pending
// divisor register and the apply logic. New divisors only take effect at a
// falling output edge (or immediately when stopped), so the output never
// produces a runt phase.
module acss2_clkdiv_ch
  import acss2_clk_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DIV_RST = SS_DIV_RST_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div,
  input  logic             load,
  output logic             busy,
  output logic             clk_out
);

  localparam logic [DIV_W-1:0] RST_VAL = DIV_W'(DIV_RST);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  logic [DIV_W-1:0] cur;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] pend;
  logic             pend_v;
  logic             clk_q;

  logic             stopped;
  logic             term;
  logic             apply;

  // Terminal-count and apply-point decode.
  always_comb begin
    stopped = (cur == '0);
    term    = !stopped && (cnt == (cur - ONE));
    apply   = pend_v && (stopped || (term && clk_q));
  end

  // Counter, output flop and pending-divisor handling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur    <= RST_VAL;
      cnt    <= '0;
      clk_q  <= 1'b0;
      pend   <= '0;
      pend_v <= 1'b0;
    end else begin
      if (stopped) begin
        clk_q <= 1'b0;
        cnt   <= '0;
      end else if (term) begin
        clk_q <= ~clk_q;
        cnt   <= '0;
      end else begin
        cnt <= cnt + ONE;
      end

      if (apply) begin
        cur <= pend;
      end

      // A load in the apply cycle keeps pend_v set for the new value.
      if (load) begin
        pend   <= div;
        pend_v <= 1'b1;
      end else if (apply) begin
        pend_v <= 1'b0;
      end
    end
  end

  assign busy    = pend_v;
  assign clk_out = clk_q;

endmodule

// File: rtl/acss2_clkgen.sv
// ACSS2 clock generator: two independent divided clocks (SS and RCC) for the
// clock-buffer stage. Purely structural.
module acss2_clkgen
  import acss2_clk_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int SS_DIV_RST  = SS_DIV_RST_DEF,
  parameter int RCC_DIV_RST = RCC_DIV_RST_DEF
) (
  input  logic             SYS_CLK,
  input  logic             SYS_RST_N,
  input  logic [DIV_W-1:0] SS_DIV,
  input  logic             SS_DIV_LOAD,
  output logic             SS_DIV_BUSY,
  input  logic [DIV_W-1:0] RCC_DIV,
  input  logic             RCC_DIV_LOAD,
  output logic             RCC_DIV_BUSY,
  output logic             SS_CLK_UNBUF,
  output logic             RCC_CLK_UNBUF
);

  acss2_clkdiv_ch #(
    .DIV_W   (DIV_W),
    .DIV_RST (SS_DIV_RST)
  ) u_ss (
    .clk     (SYS_CLK),
    .rst_n   (SYS_RST_N),
    .div     (SS_DIV),
    .load    (SS_DIV_LOAD),
    .busy    (SS_DIV_BUSY),
    .clk_out (SS_CLK_UNBUF)
  );

  acss2_clkdiv_ch #(
    .DIV_W   (DIV_W),
    .DIV_RST (RCC_DIV_RST)
  ) u_rcc (
    .clk     (SYS_CLK),
    .rst_n   (SYS_RST_N),
    .div     (RCC_DIV),
    .load    (RCC_DIV_LOAD),
    .busy    (RCC_DIV_BUSY),
    .clk_out (RCC_CLK_UNBUF)
  );

endmodule

// File: tb/tb_acss2_clkgen.sv
// Bench for acss2_clkgen: phase-based reference model of both channels,
// directed scenarios with literal expectations, then random divisor loads.
module tb_acss2_clkgen;
  import acss2_clk_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  div_t ss_div = '0;
  div_t rcc_div = '0;
  logic ss_load = 1'b0;
  logic rcc_load = 1'b0;
  logic ss_busy, rcc_busy, ss_clk, rcc_clk;

  always #5 clk = ~clk;

  acss2_clkgen dut (
    .SYS_CLK       (clk),
    .SYS_RST_N     (rst_n),
    .SS_DIV        (ss_div),
    .SS_DIV_LOAD   (ss_load),
    .SS_DIV_BUSY   (ss_busy),
    .RCC_DIV       (rcc_div),
    .RCC_DIV_LOAD  (rcc_load),
    .RCC_DIV_BUSY  (rcc_busy),
    .SS_CLK_UNBUF  (ss_clk),
    .RCC_CLK_UNBUF (rcc_clk)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs as seen by the DUT on each rising edge.
  logic cap_valid;
  logic cap_ss_load, cap_rcc_load;
  div_t cap_ss_div, cap_rcc_div;
  always @(posedge clk) begin
    cap_valid    <= rst_n;
    cap_ss_load  <= ss_load;
    cap_ss_div   <= ss_div;
    cap_rcc_load <= rcc_load;
    cap_rcc_div  <= rcc_div;
  end

  // Model per channel: active half-period, output level, cycles left in the
  // current phase, pending value and flag. Index 0 = SS, 1 = RCC.
  int m_h[2], m_lvl[2], m_rem[2], m_pv[2], m_pd[2];
  int ecount = 0;

  function automatic void mreset();
    m_h[0] = SS_DIV_RST_DEF;  m_rem[0] = SS_DIV_RST_DEF;
    m_h[1] = RCC_DIV_RST_DEF; m_rem[1] = RCC_DIV_RST_DEF;
    for (int c = 0; c < 2; c++) begin
      m_lvl[c] = 0; m_pv[c] = 0; m_pd[c] = 0;
    end
  endfunction

  function automatic void mstep(input int c, input bit ld, input int dv);
    bit took;
    took = 1'b0;
    if (m_h[c] == 0) begin
      if (m_pv[c] != 0) begin
        m_h[c] = m_pd[c]; m_rem[c] = m_h[c]; m_lvl[c] = 0; took = 1'b1;
      end
    end else begin
      m_rem[c] = m_rem[c] - 1;
      if (m_rem[c] == 0) begin
        if (m_lvl[c] == 0) begin
          m_lvl[c] = 1;
        end else begin
          m_lvl[c] = 0;
          if (m_pv[c] != 0) begin
            m_h[c] = m_pd[c]; took = 1'b1;
          end
        end
        m_rem[c] = m_h[c];
      end
    end
    if (ld) begin
      m_pd[c] = dv; m_pv[c] = 1;
    end else if (took) begin
      m_pv[c] = 0;
    end
  endfunction

  // Advance the model by the edge that just happened, then compare.
  always @(negedge clk) begin
    if (!rst_n || cap_valid !== 1'b1) begin
      mreset();
      ecount = 0;
    end else begin
      mstep(0, cap_ss_load, int'(cap_ss_div));
      mstep(1, cap_rcc_load, int'(cap_rcc_div));
      ecount++;
    end
    chk("ss_clk_model", int'(ss_clk), m_lvl[0]);
    chk("ss_busy_model", int'(ss_busy), m_pv[0]);
    chk("rcc_clk_model", int'(rcc_clk), m_lvl[1]);
    chk("rcc_busy_model", int'(rcc_busy), m_pv[1]);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Waits for the next SS rising edge and returns the high-phase length.
  task automatic measure_high(output int len);
    int n;
    len = -1;
    n = 0;
    while (ss_clk !== 1'b0 && n < 60) begin tick(); n++; end
    while (ss_clk !== 1'b1 && n < 60) begin tick(); n++; end
    if (n >= 60) begin
      chk("measure_high_timeout", n, 0);
    end else begin
      len = 0;
      while (ss_clk === 1'b1 && len < 300) begin len++; tick(); end
    end
  endtask

  task automatic first_rises(output int ss_r, output int rcc_r);
    ss_r = -1;
    rcc_r = -1;
    for (int i = 0; i < 8 && ecount < 5; i++) begin
      tick();
      if (ss_clk === 1'b1 && ss_r < 0) ss_r = ecount;
      if (rcc_clk === 1'b1 && rcc_r < 0) rcc_r = ecount;
    end
  endtask

  initial begin
    int ss_r, rcc_r, len, n, highs, rises;
    logic prev;

    // Reset defaults
    repeat (3) tick();
    chk("rst_ss_clk", int'(ss_clk), 0);
    chk("rst_rcc_clk", int'(rcc_clk), 0);
    chk("rst_ss_busy", int'(ss_busy), 0);
    chk("rst_rcc_busy", int'(rcc_busy), 0);
    rst_n = 1'b1;
    first_rises(ss_r, rcc_r);
    chk("ss_first_rise_edge", ss_r, 4);
    chk("rcc_first_rise_edge", rcc_r, 2);
    chk("busy_idle", int'(ss_busy) + int'(rcc_busy), 0);

    // SS 4 -> 1 loaded mid-high (ecount = 5, high since edge 4)
    ss_div = 8'd1; ss_load = 1'b1;
    tick(); ss_load = 1'b0;
    chk("h1_busy_e6", int'(ss_busy), 1);
    tick();
    chk("h1_busy_e7", int'(ss_busy), 1);
    chk("h1_clk_e7", int'(ss_clk), 1);
    tick();
    chk("h1_busy_e8", int'(ss_busy), 0);
    chk("h1_clk_e8", int'(ss_clk), 0);
    tick(); chk("h1_clk_e9", int'(ss_clk), 1);
    tick(); chk("h1_clk_e10", int'(ss_clk), 0);
    tick(); chk("h1_clk_e11", int'(ss_clk), 1);

    // Stop, then restart with H = 3
    ss_div = 8'd0; ss_load = 1'b1;
    tick(); ss_load = 1'b0;
    n = 0;
    while (ss_busy === 1'b1 && n < 10) begin tick(); n++; end
    chk("stop_apply_timeout", int'(n >= 10), 0);
    chk("stop_parked_low", int'(ss_clk), 0);
    highs = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (ss_clk !== 1'b0) highs++;
    end
    chk("stop_high_count", highs, 0);
    ss_div = 8'd3; ss_load = 1'b1;
    tick(); ss_load = 1'b0;
    chk("restart_busy_set", int'(ss_busy), 1);
    tick();
    chk("restart_busy_clear", int'(ss_busy), 0);
    chk("restart_low_t1", int'(ss_clk), 0);
    tick(); tick();
    chk("restart_low_t3", int'(ss_clk), 0);
    tick();
    chk("restart_first_rise", int'(ss_clk), 1);
    measure_high(len);
    chk("restart_high_len", len, 3);

    // Back-to-back loads 5 then 7
    ss_div = 8'd5; ss_load = 1'b1;
    tick();
    ss_div = 8'd7;
    tick(); ss_load = 1'b0;
    n = 0;
    while (ss_busy === 1'b1 && n < 20) begin tick(); n++; end
    chk("b2b_apply_timeout", int'(n >= 20), 0);
    rises = 0;
    prev = ss_busy;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ss_busy === 1'b1 && prev === 1'b0) rises++;
      prev = ss_busy;
    end
    chk("b2b_busy_repulse", rises, 0);
    measure_high(len);
    chk("b2b_high_len", len, 7);

    // Load coinciding with the apply cycle
    ss_div = 8'd2; ss_load = 1'b1;
    tick(); ss_load = 1'b0;
    n = 0;
    while (!(m_lvl[0] == 1 && m_rem[0] == 1 && m_pv[0] == 1) && n < 40) begin
      tick(); n++;
    end
    chk("coinc_setup_timeout", int'(n >= 40), 0);
    ss_div = 8'd6; ss_load = 1'b1;
    tick(); ss_load = 1'b0;
    chk("coinc_fell", int'(ss_clk), 0);
    chk("coinc_busy_kept", int'(ss_busy), 1);
    measure_high(len);
    chk("coinc_old_high_len", len, 2);
    chk("coinc_busy_cleared", int'(ss_busy), 0);
    measure_high(len);
    chk("coinc_new_high_len", len, 6);

    // Async reset mid-period with pending values
    ss_div = 8'd9; ss_load = 1'b1;
    rcc_div = 8'd5; rcc_load = 1'b1;
    tick(); ss_load = 1'b0; rcc_load = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ss_clk", int'(ss_clk), 0);
    chk("arst_rcc_clk", int'(rcc_clk), 0);
    chk("arst_ss_busy", int'(ss_busy), 0);
    chk("arst_rcc_busy", int'(rcc_busy), 0);
    tick();
    rst_n = 1'b1;
    first_rises(ss_r, rcc_r);
    chk("arst_ss_first_rise", ss_r, 4);
    chk("arst_rcc_first_rise", rcc_r, 2);
    chk("arst_pend_dropped", int'(ss_busy) + int'(rcc_busy), 0);

    // Random loads on both channels
    for (int i = 0; i < 3000; i++) begin
      ss_load  = ($urandom_range(0, 15) == 0);
      rcc_load = ($urandom_range(0, 11) == 0);
      ss_div   = ($urandom_range(0, 9) == 0) ? div_t'($urandom_range(0, 20))
                                             : div_t'($urandom_range(0, 6));
      rcc_div  = ($urandom_range(0, 9) == 0) ? div_t'($urandom_range(0, 20))
                                             : div_t'($urandom_range(0, 6));
      tick();
    end
    ss_load = 1'b0;
    rcc_load = 1'b0;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acss2_clkgen.md
# acss2_clkgen

Programmable clock generator that produces the two unbuffered clocks, SS_CLK_UNBUF and RCC_CLK_UNBUF, consumed by the ACSS2 clock-buffer stage. Each output is a flop-driven divided version of SYS_CLK with an independent, software-loaded half-period. Divider changes are applied only at a falling output edge, so no runt pulses appear on the downstream buffered clock tree. A divisor of zero parks the clock low, which gives a clean stop/start mechanism.

## Interface

Parameters:
- DIV_W, 8, width of each half-period field
- SS_DIV_RST, 4, SS half-period after reset, in SYS_CLK cycles (0 = stopped)
- RCC_DIV_RST, 2, RCC half-period after reset (0 = stopped)

Ports:
- SYS_CLK  in  1  source clock; the only clock in the block
- SYS_RST_N  in  1  asynchronous, active-low reset
- SS_DIV  in  DIV_W  requested SS half-period H (period = 2H SYS_CLK cycles; 0 = stop low)
- SS_DIV_LOAD  in  1  single-cycle strobe; SS_DIV is captured into the SS pending register
- SS_DIV_BUSY  out  1  high while an SS pending value is not yet applied
- RCC_DIV  in  DIV_W  requested RCC half-period (same encoding as SS_DIV)
- RCC_DIV_LOAD  in  1  strobe for RCC_DIV
- RCC_DIV_BUSY  out  1  RCC pending flag
- SS_CLK_UNBUF  out  1  divided SS clock, driven directly from a flop
- RCC_CLK_UNBUF  out  1  divided RCC clock, driven directly from a flop

## Operation

Each channel (SS, RCC) is identical and fully independent. Per-channel state:
- cur: active divisor
- cnt: DIV_W-bit counter
- clk_q: output flop
- pend: pending divisor
- pend_v: pending-valid flag

Behaviour:
- **Reset:** cur = *_DIV_RST, cnt = 0, clk_q = 0, pend = 0, pend_v = 0. All outputs are 0 during reset.
- **Running (cur ≠ 0), non-terminal cycle (cnt ≠ cur−1):** cnt increments.
- **Running, terminal cycle, clk_q = 0:** clk_q goes to 1, cnt clears to 0 (rising edge).
- **Running, terminal cycle, clk_q = 1:** clk_q goes to 0, cnt clears to 0 (falling edge). If pend_v = 1, cur takes pend and pend_v clears in the same cycle. This falling edge is the only apply point while running.
- **Stopped (cur = 0):** clk_q stays 0 and cnt stays 0. If pend_v = 1, cur takes pend and pend_v clears on the next edge; counting starts from cnt = 0 with clk_q = 0.
- **Load:** when *_DIV_LOAD = 1, pend takes *_DIV and pend_v is set. A load while pend_v is already set overwrites pend (last write wins).
- **Load coinciding with an apply cycle:** the old pend is applied, the newly loaded value becomes pend, and pend_v stays 1.
- **Loading 0:** the clock stops low at the next falling edge.
- **Loading the same value as cur:** still goes through the full apply sequence; no visible change on the clock.
- *_DIV_BUSY = pend_v.

## Timing

- Outputs come straight from flops; there is no combinational path from inputs to outputs.
- BUSY rises one cycle after the LOAD strobe.
- **Stopped channel:** LOAD sampled on edge t. Apply happens on edge t+1, and BUSY falls after edge t+1. First rising clock edge is at edge t+1+H.
- **Running channel:** worst-case apply latency is 2·cur cycles after pend_v is set.
- **After reset release:** first rising edge of SS_CLK_UNBUF occurs on the SS_DIV_RST-th SYS_CLK edge. The RCC clock behaves likewise with RCC_DIV_RST.
- **Low half-period spanning a change:** this half-period already uses the new H, so every high and low phase is a whole number of cycles of a single divisor.
- **H = 1:** the output toggles every cycle (SYS_CLK/2). The maximum period is 2·(2^DIV_W − 1).
- **Asynchronous reset mid-period:** all outputs go to 0 immediately. The truncated high pulse is accepted.

## Structure

- **Package acss2_clk_pkg** holds:
  - the DIV_W default;
  - the reset-divisor constants;
  - a typedef for the divisor field.
- **Sub-module acss2_clkdiv_ch** implements one channel: counter, output flop, pending register and apply logic.
  - acss2_clkgen instantiates it twice (SS and RCC) with different reset divisors. The top level contains no other logic.

## Test plan

- **Reset defaults (DIV_W = 8, SS_DIV_RST = 4, RCC_DIV_RST = 2):** release reset.
  - SS clock: period 8, first rise at edge 4.
  - RCC clock: period 4, first rise at edge 2.
  - Both BUSY outputs stay 0.
- **SS change from H = 4 to H = 1, loaded mid-high-phase:**
  - BUSY is high for the rest of that phase.
  - Apply happens at the falling edge; no phase shorter than 1 cycle or mixed between 4 and 1.
  - Period 2 thereafter.
- **Stop then restart:**
  - Load 0: clock parks low at the next falling edge and stays low for ≥ 50 cycles.
  - Load 3: BUSY clears after 1 cycle, first rise 3 cycles later, period 6.
- **Back-to-back loads 5 then 7 within one SS period:** only 7 is applied, and BUSY is a single continuous pulse.
- **Load coinciding with the apply cycle:**
  - The old pending value (e.g. 2) is applied.
  - The new value (6) stays pending with BUSY = 1 and is applied at the following falling edge.
- **Assert SYS_RST_N low mid-period with pend_v = 1:**
  - Both clocks and both BUSY outputs go to 0 asynchronously.
  - After release, the reset divisors are used and the pending value is discarded.
- **Throughout:** the channels are checked for independence, i.e. RCC loads never perturb SS timing.
